// File: rtl/color_quantize_pipe.sv
// -----------------------------------------------------------------------------
// color_quantize_pipe
//   Pipelined per-channel colour-depth reducer. Each channel keeps k MSBs
//   (k programmable per channel) using truncate, round-to-nearest or 2x2
//   ordered dither, or passes the pixel through. Configuration is written to
//   a shadow set and copied to the active set on the first pixel of a frame.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset, clears all state
//   pix_in    input pixel, NUM_CH channels of CH_W bits, channel 0 in LSBs
//   in_valid  pix_in valid this cycle
//   in_sol    first pixel of a line (qualified by in_valid)
//   in_sof    first pixel of a frame (qualified by in_valid, implies sol)
//   cfg_we    shadow config write strobe
//   cfg_ch    target channel, values >= NUM_CH broadcast to all channels
//   cfg_bits  kept bits minus one
//   cfg_mode  0 truncate, 1 round, 2 ordered dither, 3 passthrough (global)
//   pix_out   quantised pixel, holds while out_valid=0
//   out_valid pix_out valid, exactly two cycles after in_valid
//
// Handshake: valid-only stream. A pixel is accepted on every edge where
//   in_valid=1; there is no ready, the pipeline never stalls and out_valid
//   follows in_valid with a fixed latency of two cycles.
// -----------------------------------------------------------------------------
module color_quantize_pipe #(
   parameter int CH_W   = 8,
   parameter int NUM_CH = 3,
   parameter int SEL_W  = 2,
   parameter int LVL_W  = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH*CH_W-1:0]   pix_in,
   input  logic                     in_valid,
   input  logic                     in_sol,
   input  logic                     in_sof,
   input  logic                     cfg_we,
   input  logic [SEL_W-1:0]         cfg_ch,
   input  logic [LVL_W-1:0]         cfg_bits,
   input  logic [1:0]               cfg_mode,
   output logic [NUM_CH*CH_W-1:0]   pix_out,
   output logic                     out_valid
);

   localparam logic [LVL_W:0] CHW_L = (LVL_W+1)'(CH_W);

   // Settings are stored as the shift s = CH_W - k; s = 0 means keep all bits,
   // which makes the reset value (all zero) the passthrough configuration.
   logic [LVL_W-1:0] shadow_s     [NUM_CH];
   logic [LVL_W-1:0] active_s     [NUM_CH];
   logic [LVL_W-1:0] shadow_s_nxt [NUM_CH];
   logic [LVL_W-1:0] eff_s        [NUM_CH];
   logic [1:0]       shadow_mode, active_mode, shadow_mode_nxt, eff_mode;

   logic [LVL_W:0]   req_k;
   logic [LVL_W-1:0] req_s;
   logic             commit;
   logic             x_par, y_par, cur_x, cur_y;
   logic [1:0]       bayer_t;

   logic [CH_W:0]    sum_nxt  [NUM_CH];
   logic [CH_W-1:0]  mask_nxt [NUM_CH];
   logic [CH_W:0]    v_ext;
   logic [CH_W+1:0]  dith;

   logic             s1_valid;
   logic [CH_W:0]    s1_sum  [NUM_CH];
   logic [CH_W-1:0]  s1_mask [NUM_CH];
   logic [NUM_CH*CH_W-1:0] out_nxt;

   assign commit = in_valid & in_sof;

   // Shadow next-state including this edge's write, so a write on the same
   // edge as a frame start is committed together with the rest of the set.
   always_comb begin
      req_k = {1'b0, cfg_bits} + (LVL_W+1)'(1);
      req_s = (req_k >= CHW_L) ? '0 : LVL_W'(CHW_L - req_k);
      shadow_mode_nxt = cfg_we ? cfg_mode : shadow_mode;
      for (int c = 0; c < NUM_CH; c++) begin
         shadow_s_nxt[c] = shadow_s[c];
         if (cfg_we && ((cfg_ch >= SEL_W'(NUM_CH)) || (cfg_ch == SEL_W'(c))))
            shadow_s_nxt[c] = req_s;
      end
   end

   // The frame-start pixel itself already uses the freshly committed set.
   always_comb begin
      eff_mode = commit ? shadow_mode_nxt : active_mode;
      for (int c = 0; c < NUM_CH; c++)
         eff_s[c] = commit ? shadow_s_nxt[c] : active_s[c];
   end

   // Position of the current pixel, before the parities are advanced.
   always_comb begin
      cur_x = (in_sof | in_sol) ? 1'b0 : x_par;
      cur_y = in_sof ? 1'b0 : (in_sol ? ~y_par : y_par);
      case ({cur_y, cur_x})
         2'b00:   bayer_t = 2'd0;
         2'b01:   bayer_t = 2'd2;
         2'b10:   bayer_t = 2'd3;
         default: bayer_t = 2'd1;
      endcase
   end

   // Stage 1 datapath: one extra bit of headroom so the later saturation
   // sees any carry out of the rounding/dither addition.
   always_comb begin
      v_ext = '0;
      dith  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         v_ext       = {1'b0, pix_in[c*CH_W +: CH_W]};
         dith        = ({CH_W'(0), bayer_t} << eff_s[c]) >> 2;
         mask_nxt[c] = {CH_W{1'b1}} << eff_s[c];
         case (eff_mode)
            2'd0: sum_nxt[c] = v_ext;
            2'd1: sum_nxt[c] = (eff_s[c] == '0) ? v_ext
                             : v_ext + ((CH_W+1)'(1) << (eff_s[c] - LVL_W'(1)));
            2'd2: sum_nxt[c] = v_ext + dith[CH_W:0];
            default: begin
               sum_nxt[c]  = v_ext;
               mask_nxt[c] = '1;
            end
         endcase
      end
   end

   // Stage 2 datapath: saturate before masking.
   always_comb begin
      out_nxt = '0;
      for (int c = 0; c < NUM_CH; c++)
         out_nxt[c*CH_W +: CH_W] = (s1_sum[c][CH_W] ? {CH_W{1'b1}} : s1_sum[c][CH_W-1:0])
                                   & s1_mask[c];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_mode <= '0;
         active_mode <= '0;
         x_par       <= 1'b0;
         y_par       <= 1'b0;
         s1_valid    <= 1'b0;
         out_valid   <= 1'b0;
         pix_out     <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            shadow_s[c] <= '0;
            active_s[c] <= '0;
            s1_sum[c]   <= '0;
            s1_mask[c]  <= '0;
         end
      end else begin
         shadow_mode <= shadow_mode_nxt;
         for (int c = 0; c < NUM_CH; c++)
            shadow_s[c] <= shadow_s_nxt[c];
         if (commit) begin
            active_mode <= shadow_mode_nxt;
            for (int c = 0; c < NUM_CH; c++)
               active_s[c] <= shadow_s_nxt[c];
         end
         if (in_valid) begin
            x_par <= ~cur_x;
            y_par <= cur_y;
            for (int c = 0; c < NUM_CH; c++) begin
               s1_sum[c]  <= sum_nxt[c];
               s1_mask[c] <= mask_nxt[c];
            end
         end
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
         if (s1_valid)
            pix_out <= out_nxt;
      end
   end

endmodule

// File: tb/tb_color_quantize_pipe.sv
// -----------------------------------------------------------------------------
// tb_color_quantize_pipe
//   Directed and random checks of color_quantize_pipe (CH_W=8, NUM_CH=3).
//   Expected pixels and their due cycle are queued when a pixel is driven and
//   compared by the output monitor when out_valid is seen.
// -----------------------------------------------------------------------------
module tb_color_quantize_pipe;

   localparam int CW = 8;
   localparam int NC = 3;
   localparam int PW = CW*NC;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [PW-1:0] pix_in = '0;
   logic          in_valid = 1'b0;
   logic          in_sol = 1'b0;
   logic          in_sof = 1'b0;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_ch = '0;
   logic [2:0]    cfg_bits = '0;
   logic [1:0]    cfg_mode = '0;
   logic [PW-1:0] pix_out;
   logic          out_valid;

   int            cyc = 0;
   int            n_pass = 0;
   int            n_total = 0;
   logic [PW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   logic [PW-1:0] mon_e;
   int            mon_c;

   localparam logic [PW-1:0] P0   = {8'd23, 8'd198, 8'd104};
   localparam logic [PW-1:0] FULL = {8'd255, 8'd255, 8'd255};

   color_quantize_pipe #(.CH_W(CW), .NUM_CH(NC), .SEL_W(2), .LVL_W(3)) dut (
      .clk(clk), .reset(reset), .pix_in(pix_in), .in_valid(in_valid),
      .in_sol(in_sol), .in_sof(in_sof), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_bits(cfg_bits), .cfg_mode(cfg_mode), .pix_out(pix_out),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_output: pix_out=%h at cycle %0d, nothing expected", pix_out, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            if (pix_out !== mon_e || cyc != mon_c)
               $display("FAIL pixel_out: got %h at cycle %0d, expected %h at cycle %0d",
                        pix_out, cyc, mon_e, mon_c);
            else
               n_pass++;
         end
      end
   end

   // Reference for one channel: integer arithmetic, saturate then mask.
   function automatic int ref_ch(int v, int k, int mode, int t);
      int s, r, m;
      s = CW - k;
      m = ((1 << CW) - 1) - ((1 << s) - 1);
      case (mode)
         0: r = v;
         1: r = (s == 0) ? v : v + (1 << (s - 1));
         2: r = v + ((t << s) >> 2);
         default: return v;
      endcase
      if (r > (1 << CW) - 1) r = (1 << CW) - 1;
      return r & m;
   endfunction

   task automatic drive(input bit v, input logic [PW-1:0] p, input bit sof, input bit sol,
                        input bit we, input logic [1:0] ch, input logic [2:0] bits,
                        input logic [1:0] mode, input bit chk, input logic [PW-1:0] e);
      @(negedge clk);
      in_valid = v; pix_in = p; in_sof = sof; in_sol = sol;
      cfg_we = we; cfg_ch = ch; cfg_bits = bits; cfg_mode = mode;
      if (v && chk) begin
         exp_q.push_back(e);
         exp_cyc_q.push_back(cyc + 2);
      end
   endtask

   task automatic cfg(input logic [1:0] ch, input logic [2:0] bits, input logic [1:0] mode);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, ch, bits, mode, 1'b0, '0);
   endtask

   task automatic px(input logic [PW-1:0] p, input bit sof, input bit sol, input logic [PW-1:0] e);
      drive(1'b1, p, sof, sol, 1'b0, 2'd0, 3'd0, 2'd0, 1'b1, e);
   endtask

   // Return inputs to idle and wait (bounded) for outstanding pixels.
   task automatic idle_wait();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, '0);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid: out_valid=%b expected 0", out_valid);
      else n_pass++;
      n_total++;
      if (pix_out !== '0) $display("FAIL reset_pix: pix_out=%h expected 0", pix_out);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_passthrough();
      px(P0, 1'b0, 1'b0, P0);
      idle_wait();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL passthrough_drain: %0d outstanding, expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_truncate();
      cfg(2'd3, 3'd2, 2'd0);
      px(P0, 1'b1, 1'b0, {8'd0, 8'd192, 8'd96});
      px(FULL, 1'b0, 1'b0, {8'd224, 8'd224, 8'd224});
      idle_wait();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL truncate_drain: %0d outstanding, expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_round();
      cfg(2'd3, 3'd2, 2'd1);
      px(P0, 1'b1, 1'b0, {8'd32, 8'd192, 8'd96});
      px(FULL, 1'b0, 1'b0, {8'd224, 8'd224, 8'd224});
      idle_wait();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL round_drain: %0d outstanding, expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_dither();
      logic [PW-1:0] p104;
      p104 = {8'd104, 8'd104, 8'd104};
      cfg(2'd3, 3'd2, 2'd2);
      px(p104, 1'b1, 1'b0, {8'd96, 8'd96, 8'd96});   // (0,0) offset 0
      px(p104, 1'b0, 1'b0, {8'd96, 8'd96, 8'd96});   // (1,0) offset 16
      px(p104, 1'b0, 1'b1, {8'd128, 8'd128, 8'd128}); // (0,1) offset 24
      px(p104, 1'b0, 1'b0, {8'd96, 8'd96, 8'd96});   // (1,1) offset 8
      idle_wait();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL dither_drain: %0d outstanding, expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_commit();
      cfg(2'd1, 3'd0, 2'd2);                          // shadow only, mid-frame
      px(P0, 1'b0, 1'b1, {8'd0, 8'd192, 8'd96});      // old settings, (0,0)
      px(P0, 1'b1, 1'b0, {8'd0, 8'd128, 8'd96});      // commit, ch1 k=1
      // write on the same edge as sof: ch0 k=8 applies to this pixel
      drive(1'b1, P0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd7, 2'd2, 1'b1, {8'd0, 8'd128, 8'd104});
      idle_wait();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL commit_drain: %0d outstanding, expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset_in_flight();
      drive(1'b1, FULL, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, '0);
      drive(1'b1, P0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, '0);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL flight_valid: out_valid=%b expected 0", out_valid);
      else n_pass++;
      n_total++;
      if (pix_out !== '0) $display("FAIL flight_pix: pix_out=%h expected 0", pix_out);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      px(P0, 1'b0, 1'b0, P0);   // active set reverted
      px(P0, 1'b1, 1'b0, P0);   // shadow set reverted
      idle_wait();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL flight_drain: %0d outstanding, expected 0", exp_q.size());
      else n_pass++;
   endtask

   // Every pixel is a frame start with a write on the same edge.
   task automatic test_back_to_back();
      int sk[NC];
      int sm;
      logic [1:0] ch;
      logic [2:0] bits;
      logic [1:0] mode;
      logic [PW-1:0] p, e;
      for (int c = 0; c < NC; c++) sk[c] = CW;
      sm = 0;
      for (int n = 0; n < 24; n++) begin
         ch   = 2'($urandom_range(0, 3));
         bits = 3'($urandom_range(0, 7));
         mode = 2'($urandom_range(0, 3));
         p    = PW'($urandom);
         for (int c = 0; c < NC; c++)
            if (int'(ch) >= NC || int'(ch) == c)
               sk[c] = (int'(bits) + 1 > CW) ? CW : int'(bits) + 1;
         sm = int'(mode);
         for (int c = 0; c < NC; c++)
            e[c*CW +: CW] = CW'(ref_ch(int'(p[c*CW +: CW]), sk[c], sm, 0));
         drive(1'b1, p, 1'b1, 1'b0, 1'b1, ch, bits, mode, 1'b1, e);
      end
      idle_wait();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL b2b_drain: %0d outstanding, expected 0", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_truncate();
      test_round();
      test_dither();
      test_commit();
      test_reset_in_flight();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/color_quantize_pipe.md
Name: color_quantize_pipe

Overview:
- Parametrised, pipelined per-channel colour-depth reducer for the video datapath.
- Sits between the pixel source and the frame/VGA output.
- Each of NUM_CH channels keeps a runtime-programmable number of MSBs, using truncate, round-to-nearest, or 2x2 ordered dither.
- Configuration is double-buffered and committed at frame start, so a frame is never rendered with mixed settings.

Parameters:
- CH_W, 8, bits per colour channel (4..12)
- NUM_CH, 3, number of channels packed in a pixel, channel 0 in the LSBs
- SEL_W, 2, width of cfg_ch; must satisfy 2^SEL_W > NUM_CH
- LVL_W, 3, width of cfg_bits; 2^LVL_W >= CH_W

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pix_in  in  NUM_CH*CH_W  input pixel
- in_valid  in  1  pix_in is valid this cycle
- in_sol  in  1  qualified by in_valid; pixel is first of a line
- in_sof  in  1  qualified by in_valid; pixel is first of a frame (implies sol)
- cfg_we  in  1  write strobe for the shadow config
- cfg_ch  in  SEL_W  target channel; any value >= NUM_CH broadcasts to all channels
- cfg_bits  in  LVL_W  kept bits minus one (k = cfg_bits+1)
- cfg_mode  in  2  0 = truncate, 1 = round, 2 = ordered dither, 3 = passthrough (global, not per channel)
- pix_out  out  NUM_CH*CH_W  quantised pixel
- out_valid  out  1  pix_out valid

Behaviour:
- Reset (async): pix_out=0, out_valid=0, pipeline valids=0, x/y parity=0. Shadow and active k = CH_W for every channel; shadow and active mode = 0. Net effect is passthrough.
- Config write: on a clk edge with cfg_we=1, shadow[cfg_ch] <= min(cfg_bits+1, CH_W); shadow mode <= cfg_mode. Writes never touch the active set directly.
- Commit: on an edge where in_valid & in_sof, active <= shadow.
  - A cfg_we on the same edge is written through, so the committed value includes it.
  - The in_sof pixel itself is processed with the newly committed settings.
- Position tracking: x/y parities are sampled for a pixel before being updated.
  - in_valid & in_sof: that pixel uses x=0, y=0. After it, x=1, y=0.
  - in_valid & in_sol (no sof): that pixel uses x=0, y=~y. After it, x=1.
  - in_valid otherwise: x toggles after the pixel.
  - in_sol/in_sof are ignored when in_valid=0.
- Per channel, with v = channel value, s = CH_W-k, mask = ~((1<<s)-1):
  - mode 0: out = v & mask.
  - mode 1: if s=0, out = v. Otherwise out = min(v + (1<<(s-1)), 2^CH_W-1) & mask.
  - mode 2: t = Bayer[y][x], where Bayer[0][0]=0, [0][1]=2, [1][0]=3, [1][1]=1. off = (t<<s)>>2. out = min(v+off, 2^CH_W-1) & mask.
  - mode 3: out = v; k is ignored.
  - Sums use CH_W+1 bits internally; saturation is applied before masking, so no wrap-around.
- Pipeline:
  - Stage 1 registers the sum and mask.
  - Stage 2 saturates/masks into pix_out.
  - Latency is exactly 2 cycles: out_valid(n+2) = in_valid(n).
  - Throughput is one pixel per clock and the pipeline never stalls.
- pix_out holds its last value while out_valid=0.
- Reset mid-frame flushes in-flight pixels: out_valid drops immediately and there are no partial outputs.
- Back-to-back in_sof pixels each commit.

Test Plan:
- Reset, then pix_in={23,198,104} with in_valid=1 and no config writes -> after 2 clocks out_valid=1, pix_out={23,198,104} (passthrough).
- Write cfg_ch=3 (broadcast), cfg_bits=2, cfg_mode=0. Send in_sof pixel {23,198,104} -> {0,192,96}. Send {255,255,255} -> {224,224,224}.
- Same config with mode=1: {23,198,104} -> {32,192,96}; {255,255,255} saturates -> {224,224,224}.
- Mode 2, k=3, channel value 104 on four pixels in positions (0,0),(1,0),(0,1),(1,1) -> 96, 96, 128, 96 (offsets 0, 16, 24, 8).
- Write cfg_bits=0 to channel 1 mid-frame -> output unchanged until the next in_sof pixel. On that pixel, channel 1 = 128 for input 198 and the other channels are unchanged. A cfg_we on the same edge as in_sof takes effect on that pixel.
- Assert reset with two pixels in flight -> out_valid=0 and pix_out=0 asynchronously. After release, the config has reverted to passthrough.
